// File: rtl/bm_solver_param_if.sv
// Handshake bundle between the syndrome calculator, the BM key-equation solver and the
// Chien/Forney stage.
//   syn_in/syn_valid/syn_ready         : syndrome block in (S_j at [(j-1)*SYM_W +: SYM_W])
//   lambda_out/deg_out/fail_out        : locator coefficients, final L, uncorrectable flag
//   out_valid/out_ready                : result handshake with backpressure
// master = producer of syndromes / consumer of results, slave = the solver.
interface bm_solver_param_if #(
    parameter int unsigned SYM_W = 8,
    parameter int unsigned NSYN  = 16
);
    localparam int unsigned DegW = $clog2(NSYN + 1);

    logic [NSYN*SYM_W-1:0]         syn_in;
    logic                          syn_valid;
    logic                          syn_ready;
    logic [(NSYN/2+1)*SYM_W-1:0]   lambda_out;
    logic [DegW-1:0]               deg_out;
    logic                          fail_out;
    logic                          out_valid;
    logic                          out_ready;

    modport master (
        output syn_in, syn_valid, out_ready,
        input  syn_ready, lambda_out, deg_out, fail_out, out_valid
    );

    modport slave (
        input  syn_in, syn_valid, out_ready,
        output syn_ready, lambda_out, deg_out, fail_out, out_valid
    );
endinterface

// File: rtl/bm_solver_param.sv
// Division-free (inverse-free) Berlekamp-Massey key-equation solver over GF(2^SYM_W).
// Accepts NSYN syndromes, runs exactly NSYN iterations (one CALC + one UPD cycle each) and
// returns the scaled error-locator Lambda_0..Lambda_T, its degree L and an uncorrectable flag.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : bm_solver_param_if.slave (syndrome input handshake, result output handshake)
module bm_solver_param #(
    parameter int unsigned     SYM_W     = 8,
    parameter int unsigned     NSYN      = 16,
    parameter logic [SYM_W:0]  PRIM_POLY = 'h11D
) (
    input  logic               clk,
    input  logic               rst,
    bm_solver_param_if.slave   bus
);
    localparam int unsigned T    = NSYN / 2;
    localparam int unsigned CW   = $clog2(NSYN + 1);
    localparam int unsigned LW   = CW + 1;
    localparam int unsigned NW   = $clog2(NSYN);
    localparam int unsigned PW   = (NSYN + 1) * SYM_W;
    localparam int unsigned LamW = (T + 1) * SYM_W;

    typedef enum logic [1:0] {StIdle, StCalc, StUpd, StDone} state_e;

    state_e                 state_q;
    logic [NSYN*SYM_W-1:0]  syn_q;
    logic [PW-1:0]          c_q, c_d;
    logic [PW-1:0]          bpoly_q, bpoly_d;
    logic [SYM_W-1:0]       bsc_q, bsc_d;
    logic [SYM_W-1:0]       d_q, disc;
    logic [LW-1:0]          l_q, l_d;
    logic [LW-1:0]          m_q, m_d;
    logic [NW-1:0]          n_q;

    logic                   syn_ready_q;
    logic                   out_valid_q;
    logic [LamW-1:0]        lambda_q;
    logic [CW-1:0]          deg_q;
    logic                   fail_q;

    // Shift-and-add GF multiply, reducing by PRIM_POLY on every shift.
    function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                                input logic [SYM_W-1:0] b);
        logic [SYM_W-1:0] acc;
        logic [SYM_W-1:0] sh;
        acc = '0;
        sh  = a;
        for (int k = 0; k < int'(SYM_W); k++) begin
            if (b[k]) acc ^= sh;
            sh = sh[SYM_W-1] ? ((sh << 1) ^ PRIM_POLY[SYM_W-1:0]) : (sh << 1);
        end
        return acc;
    endfunction

    // Discrepancy for iteration N: only terms with syndrome index N+1-i >= 1 contribute.
    always_comb begin
        disc = '0;
        for (int i = 0; i <= int'(NSYN); i++) begin
            if (i <= int'(n_q)) begin
                disc ^= gf_mul(c_q[i*SYM_W +: SYM_W], syn_q[(int'(n_q) - i)*SYM_W +: SYM_W]);
            end
        end
    end

    // Inverse-free update, all terms from pre-update values; x^m*B beyond index NSYN drops.
    always_comb begin
        c_d     = c_q;
        bpoly_d = bpoly_q;
        bsc_d   = bsc_q;
        l_d     = l_q;
        m_d     = m_q + LW'(1);
        if (d_q != '0) begin
            for (int i = 0; i <= int'(NSYN); i++) begin
                c_d[i*SYM_W +: SYM_W] = gf_mul(bsc_q, c_q[i*SYM_W +: SYM_W]);
                if (i >= int'(m_q)) begin
                    c_d[i*SYM_W +: SYM_W] ^=
                        gf_mul(d_q, bpoly_q[(i - int'(m_q))*SYM_W +: SYM_W]);
                end
            end
            if (2 * int'(l_q) <= int'(n_q)) begin
                bpoly_d = c_q;
                l_d     = LW'(n_q) + LW'(1) - l_q;
                bsc_d   = d_q;
                m_d     = LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            syn_q       <= '0;
            c_q         <= '0;
            bpoly_q     <= '0;
            bsc_q       <= '0;
            d_q         <= '0;
            l_q         <= '0;
            m_q         <= '0;
            n_q         <= '0;
            syn_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            lambda_q    <= '0;
            deg_q       <= '0;
            fail_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.syn_valid && syn_ready_q) begin
                        syn_q       <= bus.syn_in;
                        c_q         <= PW'(1);
                        bpoly_q     <= PW'(1);
                        bsc_q       <= SYM_W'(1);
                        l_q         <= '0;
                        m_q         <= LW'(1);
                        n_q         <= '0;
                        syn_ready_q <= 1'b0;
                        state_q     <= StCalc;
                    end else begin
                        syn_ready_q <= 1'b1;
                    end
                end
                StCalc: begin
                    d_q     <= disc;
                    state_q <= StUpd;
                end
                StUpd: begin
                    c_q     <= c_d;
                    bpoly_q <= bpoly_d;
                    bsc_q   <= bsc_d;
                    l_q     <= l_d;
                    m_q     <= m_d;
                    if (n_q == NW'(NSYN - 1)) begin
                        out_valid_q <= 1'b1;
                        lambda_q    <= c_d[LamW-1:0];
                        deg_q       <= l_d[CW-1:0];
                        fail_q      <= (l_d > LW'(T));
                        state_q     <= StDone;
                    end else begin
                        n_q     <= n_q + NW'(1);
                        state_q <= StCalc;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        lambda_q    <= '0;
                        deg_q       <= '0;
                        fail_q      <= 1'b0;
                        syn_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
            endcase
        end
    end

    assign bus.syn_ready  = syn_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.lambda_out = lambda_q;
    assign bus.deg_out    = deg_q;
    assign bus.fail_out   = fail_q;
endmodule

// File: tb/tb_bm_solver_param.sv
// Self-checking bench for bm_solver_param (SYM_W=8, NSYN=16, PRIM_POLY='h11D).
module tb_bm_solver_param;
    localparam int SW   = 8;
    localparam int NS   = 16;
    localparam int PP   = 'h11D;
    localparam int T    = NS / 2;
    localparam int Q    = (1 << SW) - 1;
    localparam int LAMW = (T + 1) * SW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bm_solver_param_if #(.SYM_W(SW), .NSYN(NS)) bus ();

    bm_solver_param #(.SYM_W(SW), .NSYN(NS), .PRIM_POLY(PP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int gexp[0:2*Q];
    int glog[0:Q];

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gexp[glog[a] + glog[b]];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Golden inverse-free BM on plain integer arrays with log/antilog arithmetic.
    task automatic bm_model(input logic [NS*SW-1:0] s, output logic [LAMW-1:0] lam,
                            output int deg);
        int c[NS+1];
        int bp[NS+1];
        int cn[NS+1];
        int bs, d, m, L;
        for (int i = 0; i <= NS; i++) begin
            c[i] = 0;
            bp[i] = 0;
        end
        c[0] = 1; bp[0] = 1; bs = 1; m = 1; L = 0;
        for (int n = 0; n < NS; n++) begin
            d = 0;
            for (int i = 0; i <= n; i++) d ^= gmul(c[i], int'(s[(n-i)*SW +: SW]));
            if (d == 0) begin
                m++;
            end else begin
                for (int i = 0; i <= NS; i++)
                    cn[i] = gmul(bs, c[i]) ^ ((i >= m) ? gmul(d, bp[i-m]) : 0);
                if (2 * L <= n) begin
                    bp = c; L = n + 1 - L; bs = d; m = 1;
                end else begin
                    m++;
                end
                c = cn;
            end
        end
        lam = '0;
        for (int i = 0; i <= T; i++) lam[i*SW +: SW] = SW'(c[i]);
        deg = L;
    endtask

    // Lambda evaluated at X^-1 for X = alpha^pos.
    function automatic int lam_eval(input logic [LAMW-1:0] lam, input int pos);
        int e, acc;
        e = (Q - pos) % Q;
        acc = 0;
        for (int i = 0; i <= T; i++) acc ^= gmul(int'(lam[i*SW +: SW]), gexp[(e * i) % Q]);
        return acc;
    endfunction

    // One full block: accept, run, check against the model, optional hold, handshake.
    task automatic run_block(input logic [NS*SW-1:0] s, input int hold, input bit pulse,
                             output int acc_cyc, output logic [LAMW-1:0] lam_o,
                             output int deg_o, output bit fail_o);
        logic [LAMW-1:0] lam_e;
        int deg_e, w, lat;
        bit busy_ok, stable;
        logic [LAMW-1:0] lam0;
        logic [4:0] deg0;
        bm_model(s, lam_e, deg_e);
        bus.out_ready = (hold == 0);
        bus.syn_in = s;
        bus.syn_valid = 1'b1;
        w = 0;
        while (!bus.syn_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        chk("accept_timeout", 128'(w < 100), 128'(1));
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        bus.syn_valid = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (!bus.out_valid && lat < 100) begin
            if (bus.syn_ready) busy_ok = 1'b0;
            bus.syn_valid = pulse && (lat >= 3) && (lat < 8);
            bus.syn_in = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1; lat++;
        end
        bus.syn_valid = 1'b0;
        // out_valid is first seen 2*NSYN edges after the accept edge (cycle 2*NSYN+1).
        chk("latency", 128'(lat), 128'(2 * NS));
        chk("busy_ready_low", 128'(busy_ok), 128'(1));
        chk("lambda", 128'(bus.lambda_out), 128'(lam_e));
        chk("deg", 128'(bus.deg_out), 128'(deg_e));
        chk("fail", 128'(bus.fail_out), 128'(deg_e > T));
        lam_o = bus.lambda_out;
        deg_o = int'(bus.deg_out);
        fail_o = bus.fail_out;
        if (hold > 0) begin
            lam0 = bus.lambda_out;
            deg0 = bus.deg_out;
            stable = 1'b1;
            repeat (hold) begin
                @(posedge clk); #1;
                if (!bus.out_valid || bus.syn_ready || bus.lambda_out !== lam0 ||
                    bus.deg_out !== deg0) stable = 1'b0;
            end
            chk("hold_stable", 128'(stable), 128'(1));
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("after_hs_clear",
            128'({bus.out_valid, bus.fail_out, bus.deg_out, bus.lambda_out}), 128'(0));
        chk("after_hs_ready", 128'(bus.syn_ready), 128'(1));
    endtask

    function automatic logic [NS*SW-1:0] make_syn(input int nerr, input int pos[8],
                                                  input int y[8]);
        logic [NS*SW-1:0] s;
        int sj;
        s = '0;
        for (int j = 1; j <= NS; j++) begin
            sj = 0;
            for (int k = 0; k < nerr; k++) sj ^= gmul(y[k], gexp[(pos[k] * j) % Q]);
            s[(j-1)*SW +: SW] = SW'(sj);
        end
        return s;
    endfunction

    initial begin
        int x, a1, a2, deg, nerr, cnt;
        int pos[8];
        int y[8];
        bit used[Q];
        bit fl;
        logic [LAMW-1:0] lam;
        logic [NS*SW-1:0] s;

        x = 1;
        for (int i = 0; i < Q; i++) begin
            gexp[i] = x; gexp[i+Q] = x; glog[x] = i;
            x <<= 1;
            if ((x & (1 << SW)) != 0) x ^= PP;
        end
        gexp[2*Q] = gexp[Q];
        glog[0] = 0;

        bus.syn_in = '0;
        bus.syn_valid = 1'b0;
        bus.out_ready = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_syn_ready", 128'(bus.syn_ready), 128'(0));
        chk("rst_outs",
            128'({bus.out_valid, bus.fail_out, bus.deg_out, bus.lambda_out}), 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_release_ready", 128'(bus.syn_ready), 128'(1));

        // All-zero syndromes
        run_block('0, 0, 1'b0, a1, lam, deg, fl);
        chk("zero_lambda", 128'(lam), 128'h01);
        chk("zero_deg", 128'(deg), 128'(0));

        // Single error at alpha, Y=1: S_j = alpha^j
        for (int j = 1; j <= NS; j++) s[(j-1)*SW +: SW] = SW'(gexp[j % Q]);
        run_block(s, 0, 1'b0, a1, lam, deg, fl);
        chk("single_lambda", 128'(lam), 128'h0201);
        chk("single_deg", 128'(deg), 128'(1));
        chk("single_fail", 128'(fl), 128'(0));

        // Only S16 nonzero: L jumps to NSYN, x^16 term not visible
        s = '0;
        s[(NS-1)*SW +: SW] = SW'(1);
        run_block(s, 0, 1'b0, a1, lam, deg, fl);
        chk("s16_lambda", 128'(lam), 128'h01);
        chk("s16_deg", 128'(deg), 128'(16));
        chk("s16_fail", 128'(fl), 128'(1));

        // Random correctable patterns; some with backpressure, syn_valid pulses,
        // and one back-to-back pair checked for spacing.
        for (int t = 0; t < 18; t++) begin
            nerr = $urandom_range(1, T);
            for (int i = 0; i < Q; i++) used[i] = 1'b0;
            for (int k = 0; k < 8; k++) begin
                pos[k] = 0;
                y[k] = 0;
            end
            for (int k = 0; k < nerr; k++) begin
                do pos[k] = $urandom_range(0, Q - 1); while (used[pos[k]]);
                used[pos[k]] = 1'b1;
                y[k] = $urandom_range(1, Q);
            end
            s = make_syn(nerr, pos, y);
            a1 = a2;
            run_block(s, (t == 2) ? 10 : 0, (t % 3) == 1, a2, lam, deg, fl);
            if (t == 5) chk("b2b_spacing", 128'(a2 - a1), 128'(2 * NS + 2));
            chk("rand_deg", 128'(deg), 128'(nerr));
            chk("rand_fail", 128'(fl), 128'(0));
            cnt = 0;
            for (int k = 0; k < nerr; k++) if (lam_eval(lam, pos[k]) == 0) cnt++;
            chk("rand_roots", 128'(cnt), 128'(nerr));
        end

        // Random syndromes, mostly uncorrectable; model comparison only
        for (int t = 0; t < 6; t++) begin
            for (int j = 0; j < NS; j++) s[j*SW +: SW] = SW'($urandom_range(0, Q));
            run_block(s, 0, 1'b1, a1, lam, deg, fl);
        end

        // Reset at cycle 17 of a run
        bus.out_ready = 1'b1;
        bus.syn_in = {$urandom, $urandom, $urandom, $urandom};
        bus.syn_valid = 1'b1;
        @(posedge clk); #1;
        bus.syn_valid = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.syn_valid = 1'b1;
        @(posedge clk); #1;
        bus.syn_valid = 1'b0;
        chk("midrst_outs",
            128'({bus.out_valid, bus.fail_out, bus.deg_out, bus.lambda_out}), 128'(0));
        chk("midrst_ready", 128'(bus.syn_ready), 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_idle_ready", 128'(bus.syn_ready), 128'(1));
        run_block('0, 0, 1'b0, a1, lam, deg, fl);
        chk("midrst_zero_lambda", 128'(lam), 128'h01);

        // Reset while holding a result in DONE
        bus.out_ready = 1'b0;
        s = '0;
        s[(NS-1)*SW +: SW] = SW'(1);
        bus.syn_in = s;
        bus.syn_valid = 1'b1;
        @(posedge clk); #1;
        bus.syn_valid = 1'b0;
        repeat (2 * NS) @(posedge clk);
        #1;
        chk("done_valid", 128'(bus.out_valid), 128'(1));
        rst = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("donerst_outs",
            128'({bus.out_valid, bus.fail_out, bus.deg_out, bus.lambda_out}), 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("donerst_ready", 128'(bus.syn_ready), 128'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
